// File: rtl/fifo_pkt_writer.sv
`default_nettype none
// ============================================================================
// Module   : fifo_pkt_writer
// Purpose  : Write-side packet framer for the asynchronous FIFO. Each packet
//            is written as one header word (payload length), the payload
//            words and one XOR checksum trailer, all under the FIFO's
//            full backpressure. Runs entirely in the wr_clk domain.
// Ports    : wr_clk, rst_n       - write clock, async active-low reset
//            cmd_valid/ready/len - length command handshake
//            s_valid/ready/data  - payload word stream
//            full                - FIFO full flag (wr_clk domain)
//            wr_EN, data_in      - FIFO write port
//            busy                - packet in progress
//            len_err             - one-cycle pulse on an illegal command
//            pkt_cnt             - completed packets (wraps)
//            stall_cnt           - cycles blocked by full (saturates)
// Revision : 1.0 - initial release
// ============================================================================
module fifo_pkt_writer #(
    parameter  int WIDTH   = 8,
    parameter  int MAX_LEN = 16,
    localparam int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic             wr_clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_data,
    input  logic             full,
    output logic             wr_EN,
    output logic [WIDTH-1:0] data_in,
    output logic             busy,
    output logic             len_err,
    output logic [15:0]      pkt_cnt,
    output logic [15:0]      stall_cnt
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_HDR     = 2'd1;
    localparam logic [1:0] S_PAYLOAD = 2'd2;
    localparam logic [1:0] S_TRAIL   = 2'd3;

    logic [1:0]       state_q,     state_d;
    logic [LEN_W-1:0] rem_q,       rem_d;
    logic [WIDTH-1:0] csum_q,      csum_d;
    logic             len_err_q,   len_err_d;
    logic [15:0]      pkt_cnt_q,   pkt_cnt_d;
    logic [15:0]      stall_cnt_q, stall_cnt_d;

    logic             w_cmd_fire;
    logic             w_len_bad;

    assign w_cmd_fire = cmd_valid && cmd_ready;
    assign w_len_bad  = (cmd_len == '0) || (cmd_len > LEN_W'(MAX_LEN));

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge wr_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            rem_q       <= '0;
            csum_q      <= '0;
            len_err_q   <= 1'b0;
            pkt_cnt_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            csum_q      <= csum_d;
            len_err_q   <= len_err_d;
            pkt_cnt_q   <= pkt_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and datapath update
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        csum_d      = csum_q;
        len_err_d   = 1'b0;
        pkt_cnt_d   = pkt_cnt_q;
        stall_cnt_d = stall_cnt_q;

        // Any blocked cycle inside a packet is a stall, even without payload.
        if ((state_q != S_IDLE) && full && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end

        case (state_q)
            S_IDLE: begin
                if (w_cmd_fire) begin
                    if (w_len_bad) begin
                        len_err_d = 1'b1;
                    end else begin
                        rem_d   = cmd_len;
                        // Header word is folded into the checksum up front.
                        csum_d  = WIDTH'(cmd_len);
                        state_d = S_HDR;
                    end
                end
            end
            S_HDR: begin
                if (!full) begin
                    state_d = S_PAYLOAD;
                end
            end
            S_PAYLOAD: begin
                if (s_valid && !full) begin
                    csum_d = csum_q ^ s_data;
                    rem_d  = rem_q - LEN_W'(1);
                    if (rem_q == LEN_W'(1)) begin
                        state_d = S_TRAIL;
                    end
                end
            end
            S_TRAIL: begin
                if (!full) begin
                    pkt_cnt_d = pkt_cnt_q + 16'd1;
                    state_d   = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs: zero-cycle response to full; data_in is zero unless writing
    // ------------------------------------------------------------------
    always_comb begin
        cmd_ready = 1'b0;
        s_ready   = 1'b0;
        wr_EN     = 1'b0;
        data_in   = '0;
        case (state_q)
            S_IDLE: begin
                cmd_ready = 1'b1;
            end
            S_HDR: begin
                wr_EN = !full;
                if (!full) data_in = WIDTH'(rem_q);
            end
            S_PAYLOAD: begin
                s_ready = !full;
                wr_EN   = s_valid && !full;
                if (s_valid && !full) data_in = s_data;
            end
            S_TRAIL: begin
                wr_EN = !full;
                if (!full) data_in = csum_q;
            end
            default: ;
        endcase
    end

    assign busy      = (state_q != S_IDLE);
    assign len_err   = len_err_q;
    assign pkt_cnt   = pkt_cnt_q;
    assign stall_cnt = stall_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_fifo_pkt_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_pkt_writer
// Purpose  : Self-checking bench for fifo_pkt_writer. Expected FIFO words are
//            pushed to a scoreboard when a packet is launched and popped by a
//            monitor on every observed write.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_pkt_writer;

    localparam int WIDTH   = 8;
    localparam int MAX_LEN = 16;
    localparam int LEN_W   = $clog2(MAX_LEN + 1);

    logic             wr_clk;
    logic             rst_n;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [LEN_W-1:0] cmd_len;
    logic             s_valid;
    logic             s_ready;
    logic [WIDTH-1:0] s_data;
    logic             full;
    logic             wr_EN;
    logic [WIDTH-1:0] data_in;
    logic             busy;
    logic             len_err;
    logic [15:0]      pkt_cnt;
    logic [15:0]      stall_cnt;

    int n_checks = 0;
    int n_errs   = 0;
    int cyc      = 0;

    logic [WIDTH-1:0] exp_q[$];
    int               wr_cyc_q[$];
    logic [WIDTH-1:0] pay [16];

    fifo_pkt_writer #(.WIDTH(WIDTH), .MAX_LEN(MAX_LEN)) dut (
        .wr_clk    (wr_clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_len   (cmd_len),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .full      (full),
        .wr_EN     (wr_EN),
        .data_in   (data_in),
        .busy      (busy),
        .len_err   (len_err),
        .pkt_cnt   (pkt_cnt),
        .stall_cnt (stall_cnt)
    );

    initial begin
        wr_clk = 1'b0;
        forever #5 wr_clk = ~wr_clk;
    end

    always @(posedge wr_clk) cyc <= cyc + 1;

    // Monitor: inputs settle shortly after posedge, so the negedge view is
    // exactly what the FIFO sees at the next rising edge.
    always @(negedge wr_clk) begin
        if (rst_n) begin
            if (wr_EN) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_errs++;
                    $display("FAIL unexpected_write: got %02h, expected no write", data_in);
                end else begin
                    logic [WIDTH-1:0] e;
                    e = exp_q.pop_front();
                    if (data_in !== e) begin
                        n_errs++;
                        $display("FAIL write_data: got %02h, expected %02h", data_in, e);
                    end
                end
                wr_cyc_q.push_back(cyc);
            end else begin
                n_checks++;
                if (data_in !== '0) begin
                    n_errs++;
                    $display("FAIL idle_data: got %02h, expected 00", data_in);
                end
            end
            if (full) begin
                n_checks++;
                if (wr_EN !== 1'b0 || s_ready !== 1'b0) begin
                    n_errs++;
                    $display("FAIL full_block: wr_EN=%b s_ready=%b, expected 0 0", wr_EN, s_ready);
                end
            end
        end
    end

    task automatic tick();
        @(posedge wr_clk);
        #1;
    endtask

    // Called just after a posedge; returns just after the accepting edge.
    task automatic send_cmd(input int len);
        bit ok;
        ok = 1'b0;
        cmd_valid = 1'b1;
        cmd_len   = LEN_W'(len);
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge wr_clk);
            if (cmd_ready) ok = 1'b1;
            tick();
        end
        cmd_valid = 1'b0;
        if (!ok) begin
            n_checks++;
            n_errs++;
            $display("FAIL cmd_timeout: cmd_ready never high, expected acceptance");
        end
    endtask

    // Drives one packet's payload after its command is accepted. full is
    // high for cycles fs..fs+fc-1 (cycle 1 = first cycle after acceptance);
    // s_valid drops for gap_cycles cycles once gap_after words are consumed.
    task automatic run_pkt(input int len, input int fs, input int fc,
                           input int gap_after, input int gap_cycles,
                           input int abort_after, output int busy_cyc);
        int  idx, gap_left, wr;
        bit  done, gap, fire;
        logic [WIDTH-1:0] cs;
        cs = WIDTH'(len);
        exp_q.push_back(WIDTH'(len));
        for (int i = 0; i < len; i++) begin
            exp_q.push_back(pay[i]);
            cs = cs ^ pay[i];
        end
        exp_q.push_back(cs);
        idx = 0; gap_left = gap_cycles; wr = 0; done = 1'b0; busy_cyc = 0;
        for (int k = 1; k <= 200 && !done; k++) begin
            full    = (k >= fs) && (k < fs + fc);
            gap     = (idx == gap_after) && (gap_left > 0);
            s_valid = (idx < len) && !gap;
            s_data  = (idx < len) ? pay[idx] : '0;
            @(negedge wr_clk);
            if (busy) busy_cyc++;
            if (gap) gap_left--;
            fire = s_valid && s_ready;
            if (wr_EN) begin
                wr++;
                if (wr == len + 2) done = 1'b1;
            end
            tick();
            if (fire) idx++;
            if (abort_after > 0 && idx == abort_after) done = 1'b1;
        end
        full    = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        if (!done) begin
            n_checks++;
            n_errs++;
            $display("FAIL pkt_timeout: %0d of %0d writes seen", wr, len + 2);
        end
    endtask

    task automatic check_reset_values(input string tag);
        n_checks++;
        if ({cmd_ready, s_ready, wr_EN, busy, len_err} !== 5'b10000) begin
            n_errs++;
            $display("FAIL %s_flags: {cmd_ready,s_ready,wr_EN,busy,len_err}=%b, expected 10000",
                     tag, {cmd_ready, s_ready, wr_EN, busy, len_err});
        end
        n_checks++;
        if (data_in !== '0) begin
            n_errs++;
            $display("FAIL %s_data: got %02h, expected 00", tag, data_in);
        end
        n_checks++;
        if (pkt_cnt !== 16'd0 || stall_cnt !== 16'd0) begin
            n_errs++;
            $display("FAIL %s_cnts: pkt_cnt=%0d stall_cnt=%0d, expected 0 0", tag, pkt_cnt, stall_cnt);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_len = '0;
        s_valid = 1'b0; s_data = '0; full = 1'b0;
        repeat (3) @(posedge wr_clk);
        #2;
        check_reset_values("reset");
        @(negedge wr_clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        int bc;
        pay[0] = 8'hA1; pay[1] = 8'hB2; pay[2] = 8'hC3;
        wr_cyc_q.delete();
        send_cmd(3);
        run_pkt(3, 0, 0, -1, 0, 0, bc);
        check_int("single_writes", wr_cyc_q.size(), 5);
        if (wr_cyc_q.size() == 5)
            check_int("single_consecutive", wr_cyc_q[4] - wr_cyc_q[0], 4);
        check_int("single_busy_cycles", bc, 5);
        check_int("single_pkt_cnt", int'(pkt_cnt), 1);
        check_int("single_stall_cnt", int'(stall_cnt), 0);
    endtask

    task automatic test_stall();
        int bc, st0;
        pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33; pay[3] = 8'h44;
        st0 = int'(stall_cnt);
        wr_cyc_q.delete();
        send_cmd(4);
        run_pkt(4, 3, 4, -1, 0, 0, bc);
        check_int("stall_writes", wr_cyc_q.size(), 6);
        check_int("stall_cnt_delta", int'(stall_cnt) - st0, 4);
        check_int("stall_busy_cycles", bc, 10);
        check_int("stall_pkt_cnt", int'(pkt_cnt), 2);
    endtask

    task automatic test_gap();
        int bc, st0;
        pay[0] = 8'h5A; pay[1] = 8'hC3;
        st0 = int'(stall_cnt);
        wr_cyc_q.delete();
        send_cmd(2);
        run_pkt(2, 0, 0, 1, 3, 0, bc);
        check_int("gap_writes", wr_cyc_q.size(), 4);
        check_int("gap_stall_delta", int'(stall_cnt) - st0, 0);
        check_int("gap_busy_cycles", bc, 7);
        check_int("gap_pkt_cnt", int'(pkt_cnt), 3);
    endtask

    task automatic test_len_err();
        int lens [2];
        lens[0] = 0; lens[1] = 17;
        wr_cyc_q.delete();
        for (int i = 0; i < 2; i++) begin
            send_cmd(lens[i]);
            @(negedge wr_clk);
            check_int("len_err_pulse", int'(len_err), 1);
            check_int("len_err_busy", int'(busy), 0);
            tick();
            @(negedge wr_clk);
            check_int("len_err_clear", int'(len_err), 0);
            tick();
        end
        check_int("len_err_writes", wr_cyc_q.size(), 0);
        check_int("len_err_pkt_cnt", int'(pkt_cnt), 3);
    endtask

    task automatic test_back_to_back();
        int bc;
        for (int i = 0; i < 16; i++) pay[i] = WIDTH'(i * 37 + 5);
        wr_cyc_q.delete();
        send_cmd(16);
        run_pkt(16, 0, 0, -1, 0, 0, bc);
        send_cmd(16);
        run_pkt(16, 0, 0, -1, 0, 0, bc);
        check_int("b2b_writes", wr_cyc_q.size(), 36);
        if (wr_cyc_q.size() == 36)
            check_int("b2b_span", wr_cyc_q[35] - wr_cyc_q[0], 36);
        check_int("b2b_pkt_cnt", int'(pkt_cnt), 5);
    endtask

    task automatic test_reset_mid();
        int bc;
        for (int i = 0; i < 8; i++) pay[i] = WIDTH'(8'h80 + i);
        send_cmd(8);
        run_pkt(8, 0, 0, -1, 0, 3, bc);
        rst_n = 1'b0;
        #2;
        check_reset_values("reset_mid");
        exp_q.delete();
        @(negedge wr_clk);
        rst_n = 1'b1;
        tick();
        pay[0] = 8'h55;
        wr_cyc_q.delete();
        send_cmd(1);
        run_pkt(1, 0, 0, -1, 0, 0, bc);
        check_int("post_reset_writes", wr_cyc_q.size(), 3);
        check_int("post_reset_pkt_cnt", int'(pkt_cnt), 1);
    endtask

    initial begin
        test_reset();
        test_single();
        test_stall();
        test_gap();
        test_len_err();
        test_back_to_back();
        test_reset_mid();
        check_int("scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule
`default_nettype wire
